// File: rtl/timer_cmp_ctrl.sv
// Compare/interrupt controller for the 64-bit uptime counter.
// Programs a 64-bit compare value and optional period, and raises a level irq on match.
module timer_cmp_ctrl #(
  parameter bit          PERIODIC_EN = 1'b1,
  parameter logic [63:0] RESET_CMP   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [63:0] uptime,
  output logic        irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FIRED} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_cmp;
  logic [31:0] r_shadow;
  logic [31:0] r_dout;
  logic        r_en;
  logic        r_periodic;
  logic        r_ie;
  logic        r_pending;
  logic [15:0] r_missed;
  logic [63:0] w_period;
  logic [31:0] w_rdata;

  logic [2:0] w_idx;
  logic       w_wr;
  logic       w_wr_cmp_lo;
  logic       w_wr_cmp_hi;
  logic       w_wr_ctrl;
  logic       w_wr_status;
  logic       w_wr_per_lo;
  logic       w_wr_per_hi;
  logic       w_clr;
  logic       w_fire;
  logic       w_reload;
  logic       w_unused;

  assign w_idx       = addr[4:2];
  assign w_wr        = sel & we;
  assign w_wr_cmp_lo = w_wr && (w_idx == 3'd0);
  assign w_wr_cmp_hi = w_wr && (w_idx == 3'd1);
  assign w_wr_ctrl   = w_wr && (w_idx == 3'd2);
  assign w_wr_status = w_wr && (w_idx == 3'd3);
  assign w_wr_per_lo = w_wr && (w_idx == 3'd4);
  assign w_wr_per_hi = w_wr && (w_idx == 3'd5);
  assign w_clr       = w_wr_status & din[0];
  assign w_unused    = ^{addr[31:5], addr[1:0]};

  assign w_fire   = (r_state == ST_ARMED) && (uptime >= r_cmp);
  assign w_reload = w_fire && r_periodic && (w_period != 64'd0);

  generate
    if (PERIODIC_EN) begin : g_period
      logic [63:0] r_period;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_period <= 64'd0;
        end else begin
          if (w_wr_per_lo) r_period[31:0]  <= din;
          if (w_wr_per_hi) r_period[63:32] <= din;
        end
      end
      assign w_period = r_period;
    end else begin : g_no_period
      assign w_period = 64'd0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Priority: disabling beats everything; a CMP_HI commit re-arms over a one-shot fire.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_wr_ctrl && din[0]) w_state_next = ST_ARMED;
      ST_ARMED: if (w_fire && !w_reload) w_state_next = ST_FIRED;
      default:  w_state_next = r_state;
    endcase
    if (w_wr_cmp_hi && (r_state != ST_IDLE)) w_state_next = ST_ARMED;
    if (w_wr_ctrl && !din[0])                w_state_next = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cmp      <= RESET_CMP;
      r_shadow   <= 32'd0;
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_ie       <= 1'b0;
      r_pending  <= 1'b0;
      r_missed   <= 16'd0;
    end else begin
      if (w_wr_cmp_lo) r_shadow <= din;
      if (w_wr_cmp_hi)   r_cmp <= {din, r_shadow};
      else if (w_reload) r_cmp <= r_cmp + w_period;
      if (w_wr_ctrl) begin
        r_en       <= din[0];
        r_periodic <= din[1] & PERIODIC_EN;
        r_ie       <= din[2];
      end
      // A fire coinciding with a clear keeps pending set.
      if (w_fire)     r_pending <= 1'b1;
      else if (w_clr) r_pending <= 1'b0;
      if (w_clr)
        r_missed <= 16'd0;
      else if (w_fire && r_pending && (r_missed != 16'hFFFF))
        r_missed <= r_missed + 16'd1;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      3'd0: w_rdata = r_cmp[31:0];
      3'd1: w_rdata = r_cmp[63:32];
      3'd2: w_rdata = {29'd0, r_ie, r_periodic, r_en};
      3'd3: w_rdata = {r_missed, 15'd0, r_pending};
      3'd4: w_rdata = w_period[31:0];
      3'd5: w_rdata = w_period[63:32];
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)           r_dout <= 32'd0;
    else if (sel && !we) r_dout <= w_rdata;
  end

  assign dout = r_dout;
  assign irq  = r_pending & r_ie;

endmodule

// File: tb/tb_timer_cmp_ctrl.sv
// Directed self-checking bench for timer_cmp_ctrl: one-shot, atomic compare update,
// periodic, wrap/catch-up, simultaneous clear/fire, and reset/read latency.
module tb_timer_cmp_ctrl;

  localparam logic [31:0] A_CMP_LO = 32'h00;
  localparam logic [31:0] A_CMP_HI = 32'h04;
  localparam logic [31:0] A_CTRL   = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h0C;
  localparam logic [31:0] A_PER_LO = 32'h10;
  localparam logic [31:0] A_PER_HI = 32'h14;
  localparam logic [31:0] A_RSVD   = 32'h18;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] din   = 32'd0;
  logic [31:0] dout;
  logic [63:0] uptime = 64'd0;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_cmp_ctrl dut (
    .clock  (clock),
    .reset  (reset),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .uptime (uptime),
    .irq    (irq)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks are entered at a negedge and return at the following negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clock);
    sel = 1'b0; we = 1'b0;
    $display("wr addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clock);
    sel = 1'b0;
    $display("rd addr=0x%02h data=0x%08h", a, dout);
    check_eq(tag, {32'd0, dout}, {32'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_eq("reset_dout", {32'd0, dout}, 64'd0);
    check_eq("reset_irq", {63'd0, irq}, 64'd0);

    // One-shot at 100
    uptime = 64'd90;
    bus_write(A_CMP_LO, 32'd100);
    bus_write(A_CMP_HI, 32'd0);
    bus_write(A_CTRL, 32'd5);
    for (int u = 90; u <= 105; u++) begin
      uptime = 64'(u);
      @(negedge clock);
      check_eq($sformatf("oneshot_irq_u%0d", u), {63'd0, irq}, {63'd0, (u >= 100)});
    end
    read_check("oneshot_status", A_STATUS, 32'h0000_0001);
    bus_write(A_STATUS, 32'd1);
    check_eq("oneshot_irq_cleared", {63'd0, irq}, 64'd0);
    @(negedge clock);
    check_eq("oneshot_no_refire", {63'd0, irq}, 64'd0);

    // Atomic 64-bit update
    do_reset();
    uptime = 64'h0000_0000_FFFF_FFF0;
    bus_write(A_CMP_LO, 32'd0);
    bus_write(A_CMP_HI, 32'd1);
    bus_write(A_CTRL, 32'd5);
    bus_write(A_CMP_LO, 32'h10);
    @(negedge clock);
    check_eq("atomic_no_fire", {63'd0, irq}, 64'd0);
    read_check("atomic_lo_committed", A_CMP_LO, 32'd0);
    bus_write(A_CMP_HI, 32'd1);
    read_check("atomic_lo_new", A_CMP_LO, 32'h10);
    read_check("atomic_hi_new", A_CMP_HI, 32'd1);
    uptime = 64'h1_0000_000F;
    @(negedge clock);
    check_eq("atomic_below", {63'd0, irq}, 64'd0);
    uptime = 64'h1_0000_0010;
    @(negedge clock);
    check_eq("atomic_hit", {63'd0, irq}, 64'd1);

    // Periodic: fires at 50, 70, 90
    do_reset();
    uptime = 64'd0;
    bus_write(A_CMP_LO, 32'd50);
    bus_write(A_CMP_HI, 32'd0);
    bus_write(A_PER_LO, 32'd20);
    bus_write(A_PER_HI, 32'd0);
    bus_write(A_CTRL, 32'd7);
    read_check("per_ctrl", A_CTRL, 32'd7);
    for (int u = 40; u <= 95; u++) begin
      uptime = 64'(u);
      @(negedge clock);
      if (u == 49 || u == 50 || u == 95)
        check_eq($sformatf("per_irq_u%0d", u), {63'd0, irq}, {63'd0, (u >= 50)});
    end
    read_check("per_status", A_STATUS, 32'h0002_0001);
    read_check("per_cmp_lo", A_CMP_LO, 32'd110);

    // Wrap and catch-up with uptime at max
    do_reset();
    uptime = 64'hFFFF_FFFF_FFFF_FFFF;
    bus_write(A_CMP_LO, 32'hFFFF_FFF8);
    bus_write(A_CMP_HI, 32'hFFFF_FFFF);
    bus_write(A_PER_LO, 32'd16);
    bus_write(A_CTRL, 32'd7);
    read_check("wrap_cmp_before", A_CMP_LO, 32'hFFFF_FFF8);
    read_check("wrap_cmp_after", A_CMP_LO, 32'h0000_0008);
    read_check("wrap_refire_status", A_STATUS, 32'h0001_0001);
    check_eq("wrap_irq", {63'd0, irq}, 64'd1);

    // Simultaneous clear and fire
    do_reset();
    uptime = 64'd0;
    bus_write(A_CMP_LO, 32'd10);
    bus_write(A_CMP_HI, 32'd0);
    bus_write(A_PER_LO, 32'd10);
    bus_write(A_CTRL, 32'd7);
    uptime = 64'd10;
    @(negedge clock);
    uptime = 64'd20;
    @(negedge clock);
    read_check("sim_status_before", A_STATUS, 32'h0001_0001);
    uptime = 64'd30;
    bus_write(A_STATUS, 32'd1);
    check_eq("sim_irq", {63'd0, irq}, 64'd1);
    read_check("sim_status_after", A_STATUS, 32'h0000_0001);

    // Reset mid-run with bus activity, then read latency
    sel = 1'b1; we = 1'b1; addr = A_CMP_HI; din = 32'h1234;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; sel = 1'b0; we = 1'b0;
    check_eq("rst_irq", {63'd0, irq}, 64'd0);
    check_eq("rst_dout", {32'd0, dout}, 64'd0);
    sel = 1'b1; we = 1'b0; addr = A_CMP_HI;
    #2;
    check_eq("lat_before_edge", {32'd0, dout}, 64'd0);
    @(negedge clock);
    sel = 1'b0;
    $display("rd addr=0x%02h data=0x%08h", A_CMP_HI, dout);
    check_eq("lat_cmp_hi", {32'd0, dout}, 64'h0000_0000_FFFF_FFFF);
    @(negedge clock);
    check_eq("dout_hold", {32'd0, dout}, 64'h0000_0000_FFFF_FFFF);
    read_check("rst_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
    read_check("rst_ctrl", A_CTRL, 32'd0);
    read_check("rst_status", A_STATUS, 32'd0);
    read_check("rst_per_lo", A_PER_LO, 32'd0);
    read_check("rst_per_hi", A_PER_HI, 32'd0);
    bus_write(A_RSVD, 32'hABCD);
    read_check("rsvd_read", A_RSVD, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_cmp_ctrl.md
Name: timer_cmp_ctrl

Overview:
Memory-mapped compare/interrupt controller for the 64-bit uptime counter. The CPU programs a 64-bit compare value and an optional period. The block raises a level interrupt when uptime reaches the compare value, and in periodic mode it re-arms itself. It sits on the same CPU data bus as the timer read port, selected by its own sel line, and takes uptime as a synchronous input.

Parameters:
PERIODIC_EN, 1, 1 = periodic mode and PERIOD registers implemented; 0 = PERIOD registers read 0 and CTRL.periodic is tied 0
RESET_CMP, 64'hFFFF_FFFF_FFFF_FFFF, reset value of the compare register

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
sel  input  1  bus select for this block
we  input  1  write strobe; valid only with sel
addr  input  32  byte address; only addr[4:2] decoded
din  input  32  write data
dout  output  32  read data, registered
uptime  input  64  free-running uptime count, synchronous to clock
irq  output  1  level interrupt = pending & CTRL.ie

Behaviour:
- Register map (addr[4:2]):
  - 0 CMP_LO: reads the committed compare value.
  - 1 CMP_HI: reads the committed compare value.
  - 2 CTRL: bit0 en, bit1 periodic, bit2 ie.
  - 3 STATUS: bit0 pending (write 1 clears), bits31:16 missed count (read-only).
  - 4 PER_LO, 5 PER_HI: period.
  - 6–7: read 0, writes ignored.
- Reads:
  - sel & !we: dout updates on the next clock edge (1-cycle latency).
  - dout holds its value when sel is low.
- Atomic 64-bit compare update:
  - Writing CMP_LO loads a 32-bit shadow register only.
  - Writing CMP_HI commits {din, shadow} to cmp in one edge.
  - A CMP_LO read returns committed cmp[31:0], not the shadow.
- FSM states:
  - IDLE: en = 0.
  - ARMED: en = 1, waiting for uptime >= cmp (unsigned 64-bit compare).
  - FIRED: one-shot has fired; waiting for rearm.
- Transitions:
  - IDLE → ARMED: when en is written 1.
  - Any state → IDLE: when en is written 0. pending is not cleared.
  - ARMED with uptime >= cmp:
    - pending <= 1.
    - If periodic = 1 and period != 0: cmp <= cmp + period (mod 2^64); stay ARMED.
    - Otherwise: go to FIRED.
  - FIRED → ARMED: on a CMP_HI commit.
  - A CMP_HI commit in ARMED re-arms with the new value. If the new value is already <= uptime, it fires on the next compare cycle.
- Missed count:
  - Increments (saturating at 16'hFFFF) when a fire occurs while pending is already 1.
  - Cleared by the same write-1 to STATUS bit0 that clears pending.
- Simultaneous events:
  - A fire and a STATUS clear in the same cycle leave pending = 1; missed count is cleared.
  - A fire and a CMP_HI commit in the same cycle: the commit wins (cmp = new value); pending is still set by the fire.
- Periodic catch-up:
  - After a periodic fire, cmp advances by exactly one period per fire.
  - If uptime is still >= cmp, the block fires again the next cycle, with no skipping.
- Reset values:
  - dout = 0, cmp = RESET_CMP, shadow = 0, period = 0.
  - CTRL = 0, pending = 0, missed = 0, state IDLE, irq = 0.
- Reset mid-operation returns all of the above to reset values on the next edge, regardless of bus activity.

Test Plan:
- One-shot:
  - Stimulus: write CMP_LO = 100, CMP_HI = 0, CTRL = 5; ramp uptime from 90.
  - Required: irq rises the cycle after uptime = 100; FSM goes to FIRED; irq stays high until STATUS = 1 is written, then drops next cycle.
- Atomicity:
  - Stimulus: cmp = 0x1_0000_0000 armed, uptime = 0x0_FFFF_FFF0; write CMP_LO = 0x10 only.
  - Required: no fire (committed cmp unchanged). Then write CMP_HI = 1 → cmp = 0x1_0000_0010.
- Periodic:
  - Stimulus: cmp = 50, period = 20, CTRL = 7; ramp uptime.
  - Required: fires at uptime 50, 70, 90. Without clearing pending, missed = 2 after the third fire.
- Catch-up and wrap:
  - Stimulus: cmp = 0xFFFF_FFFF_FFFF_FFF8, period = 16, uptime held at max; periodic mode.
  - Required: one fire, then cmp = 0x8 (wrapped). It fires again next cycle because uptime >= 8.
- Simultaneous clear and fire:
  - Stimulus: STATUS write 1 in the same cycle as the compare match.
  - Required: pending = 1, missed = 0.
- Reset mid-run and read latency:
  - Stimulus: assert reset while ARMED with pending = 1.
  - Required: irq = 0, all registers read back at reset values. A CMP_HI read returns 0xFFFF_FFFF with exactly 1-cycle latency.
